// File: rtl/cq_param.sv
// Parametrised synchronous circular queue with occupancy count, threshold flags and error pulses.
// Latency: dout registered 1 cycle after an accepted read; CQ_FWFT_EN gives first-word-fall-through (0 cycles).
// Backpressure: writes to a full queue are rejected (overflow pulse) unless a read is accepted in the same cycle.
module cq_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 1,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic             rd,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_nxt;
  logic             rd_acc;
  logic             wr_acc;

  // A read frees a slot this cycle, so a full queue may still take a write.
  assign rd_acc = rd & ~empty;
  assign wr_acc = wr & (~full | rd_acc);

  always_comb begin
    count_nxt = count;
    if (wr_acc && !rd_acc)
      count_nxt = count + CW'(1);
    else if (rd_acc && !wr_acc)
      count_nxt = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !reset)
      mem[wr_ptr] <= din;
  end

  // Flags track next-state count so they are valid right after the changing edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc)
        wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc)
        rd_ptr <= rd_ptr + AW'(1);
      count        <= count_nxt;
      empty        <= (count_nxt == '0);
      full         <= (count_nxt == CW'(DEPTH));
      almost_empty <= (count_nxt <= CW'(AE_THRESH));
      almost_full  <= (count_nxt >= CW'(AF_THRESH));
      overflow     <= wr & ~wr_acc;
      underflow    <= rd & empty;
    end
  end

`ifdef CQ_FWFT_EN
  assign dout = empty ? '0 : mem[rd_ptr];
`else
  logic [WIDTH-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (reset)
      dout_q <= '0;
    else if (rd_acc)
      dout_q <= mem[rd_ptr];
  end

  assign dout = dout_q;
`endif

endmodule

// File: tb/tb_cq_param.sv
// Scoreboarded bench for cq_param (WIDTH=8, DEPTH=4, AF_THRESH=3, AE_THRESH=1), both dout modes.
module tb_cq_param;
  logic       clk = 1'b0;
  logic       reset, wr, rd;
  logic [7:0] din, dout;
  logic       empty, full, almost_empty, almost_full, overflow, underflow;
  logic [2:0] count;

  always #5 clk = ~clk;

  cq_param #(.WIDTH(8), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1)) dut (
    .clk(clk), .reset(reset), .wr(wr), .rd(rd), .din(din), .dout(dout),
    .empty(empty), .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  logic [7:0] m_dout;
  logic       m_ovf, m_udf;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_state();
    logic [7:0] exp_dout;
`ifdef CQ_FWFT_EN
    exp_dout = (mq.size() != 0) ? mq[0] : 8'h00;
`else
    exp_dout = m_dout;
`endif
    chk("count", 32'(count), 32'(mq.size()));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("full", 32'(full), 32'(mq.size() == 4));
    chk("almost_empty", 32'(almost_empty), 32'(mq.size() <= 1));
    chk("almost_full", 32'(almost_full), 32'(mq.size() >= 3));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_udf));
    chk("dout", 32'(dout), 32'(exp_dout));
  endtask

  task automatic cyc(input logic w, input logic r, input logic [7:0] d);
    logic racc, wacc;
    racc  = r && (mq.size() != 0);
    wacc  = w && (mq.size() < 4 || racc);
    m_ovf = w && !wacc;
    m_udf = r && (mq.size() == 0);
    if (racc) exp_q.push_back(mq[0]);
    wr = w; rd = r; din = d;
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0;
    if (racc) m_dout = mq.pop_front();
    if (wacc) mq.push_back(d);
    check_state();
  endtask

  task automatic do_reset(input logic w, input logic [7:0] d);
    reset = 1'b1; wr = w; din = d;
    @(posedge clk);
    #1;
    reset = 1'b0; wr = 1'b0;
    mq.delete();
    m_dout = 8'h00; m_ovf = 1'b0; m_udf = 1'b0;
    check_state();
  endtask

  // Monitor: an accepted read (rd while non-empty) is the DUT presenting a word.
  initial begin
    forever begin
      @(posedge clk);
      if (rd === 1'b1 && empty === 1'b0 && reset === 1'b0) begin
`ifndef CQ_FWFT_EN
        #2;
`endif
        if (exp_q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL sb_unexpected: got %0h expected none", dout);
        end else begin
          chk("sb_dout", 32'(dout), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    logic [7:0] fill_a [4];
    fill_a = '{8'h0A, 8'h01, 8'h02, 8'h04};
    reset = 1'b0; wr = 1'b0; rd = 1'b0; din = 8'h00;
    m_dout = 8'h00; m_ovf = 1'b0; m_udf = 1'b0;
    #2;
    do_reset(1'b0, 8'h00);

    // Fill, overflow attempt, pulse must drop on the idle cycle, then drain in order.
    foreach (fill_a[i]) cyc(1'b1, 1'b0, fill_a[i]);
    cyc(1'b1, 1'b0, 8'h09);
    cyc(1'b0, 1'b0, 8'h00);
    repeat (4) cyc(1'b0, 1'b1, 8'h00);

    // Underflow holds dout; write+read on empty stores the write and flags underflow.
    cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b1, 1'b1, 8'h06);
    cyc(1'b0, 1'b1, 8'h00);

    // Simultaneous write+read at full.
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'h11 + 8'(i));
    cyc(1'b1, 1'b1, 8'h05);
    repeat (4) cyc(1'b0, 1'b1, 8'h00);

    // Pointer wrap-around.
    for (int i = 1; i <= 10; i++) begin
      cyc(1'b1, 1'b0, 8'(i));
      cyc(1'b0, 1'b1, 8'h00);
    end

    // Reset mid-operation with a pending write, then a plain write with no read.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'h21 + 8'(i));
    do_reset(1'b1, 8'h30);
    cyc(1'b1, 1'b0, 8'h07);
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);

    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
